xillybus_mem_port: RTL

- Parametrised seekable memory endpoint for a Xillybus address-mapped stream pair (user_w_mem_* / user_r_mem_* / user_mem_addr*). Generalises the fixed 8-bit x 32-entry mem_8 endpoint.
- Configurable data width and depth; optional non-wrapping mode with EOF/full signalling at end of range.
- Second, fabric-side port so user logic can read and write the same RAM concurrently.
- Sits in the user region between the core's stream ports and application logic, entirely in the bus_clk domain.

---
 rtl/xillybus_mem_pkg.sv | 18 +
 rtl/xillybus_mem_port_if.sv | 45 ++++
 rtl/xillybus_tdp_ram.sv | 49 ++++
 rtl/xillybus_mem_port.sv | 86 ++++++++
 4 files changed

// File: rtl/xillybus_mem_pkg.sv
// Shared sizing defaults and range helpers for the Xillybus seekable memory endpoint.
// The end-of-range address is the last word that a non-wrapping host pointer can reach.
package xillybus_mem_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 5;

  function automatic int depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic int last_addr(input int addr_w);
    return depth(addr_w) - 1;
  endfunction

  localparam int DEF_LAST_ADDR = last_addr(DEF_ADDR_W);

endpackage

// File: rtl/xillybus_mem_port_if.sv
// Host stream pair, seek channel and fabric-side local port of the memory endpoint.
// The slave modport is the endpoint. The master modport is the core or the user logic that drives it.
interface xillybus_mem_port_if
  import xillybus_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic              user_w_mem_wren;
  logic [DATA_W-1:0] user_w_mem_data;
  logic              user_w_mem_full;
  logic              user_w_mem_open;
  logic              user_r_mem_rden;
  logic [DATA_W-1:0] user_r_mem_data;
  logic              user_r_mem_empty;
  logic              user_r_mem_eof;
  logic              user_r_mem_open;
  logic [ADDR_W-1:0] user_mem_addr;
  logic              user_mem_addr_update;
  logic              loc_en;
  logic              loc_we;
  logic [ADDR_W-1:0] loc_addr;
  logic [DATA_W-1:0] loc_wdata;
  logic [DATA_W-1:0] loc_rdata;

  modport slave (
    input  user_w_mem_wren, user_w_mem_data, user_w_mem_open,
    input  user_r_mem_rden, user_r_mem_open,
    input  user_mem_addr, user_mem_addr_update,
    input  loc_en, loc_we, loc_addr, loc_wdata,
    output user_w_mem_full, user_r_mem_data, user_r_mem_empty, user_r_mem_eof,
    output loc_rdata
  );

  modport master (
    output user_w_mem_wren, user_w_mem_data, user_w_mem_open,
    output user_r_mem_rden, user_r_mem_open,
    output user_mem_addr, user_mem_addr_update,
    output loc_en, loc_we, loc_addr, loc_wdata,
    input  user_w_mem_full, user_r_mem_data, user_r_mem_empty, user_r_mem_eof,
    input  loc_rdata
  );

endinterface

// File: rtl/xillybus_tdp_ram.sv
// True dual-port, read-first, single-clock RAM. Port A serves the host and port B serves the local side.
// The read registers have an async reset. The array itself is never reset.
module xillybus_tdp_ram
  import xillybus_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_en_i,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  output logic [DATA_W-1:0] a_rdata_o,
  input  logic              b_en_i,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  output logic [DATA_W-1:0] b_rdata_o
);

  localparam int DEPTH = depth(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

  // NOTE: the array stays out of the reset domain so it maps onto block RAM; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (b_we_i) mem_q[b_addr_i] <= b_wdata_i;
    if (a_we_i) mem_q[a_addr_i] <= a_wdata_i;
  end

  // NOTE: non-blocking reads sample the pre-edge array, which gives read-first behaviour on both ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (a_en_i) a_rdata_q <= mem_q[a_addr_i];
      if (b_en_i) b_rdata_q <= mem_q[b_addr_i];
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/xillybus_mem_port.sv
// Seekable Xillybus memory endpoint. One host pointer is shared by the read and write streams.
// An optional end-of-range stop raises EOF/full, and a concurrent local port accesses the same RAM.
module xillybus_mem_port
  import xillybus_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WRAP   = 1
) (
  input  logic               bus_clk,
  input  logic               bus_rst_n,
  xillybus_mem_port_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(last_addr(ADDR_W));

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              at_end_q, at_end_d;
  logic              r_open_q, w_open_q;
  logic              end_flag;
  logic              seek;
  logic              host_wr;
  logic              host_rd;
  logic              file_close;
  logic              loc_wr;

  assign end_flag   = (WRAP != 0) ? 1'b0 : at_end_q;
  assign seek       = bus.user_mem_addr_update;
  assign host_wr    = !seek && bus.user_w_mem_wren && !end_flag;
  assign host_rd    = !seek && bus.user_r_mem_rden && !end_flag;
  assign file_close = (r_open_q && !bus.user_r_mem_open) || (w_open_q && !bus.user_w_mem_open);

  // A local write that hits the word the host is writing this cycle is dropped, so the host data wins.
  assign loc_wr = bus.loc_en && bus.loc_we && !(host_wr && (bus.loc_addr == ptr_q));

  // NOTE: defaults first so every path assigns ptr_d/at_end_d and no latch is inferred.
  always_comb begin
    ptr_d    = ptr_q;
    at_end_d = at_end_q;
    if (seek) begin
      ptr_d    = bus.user_mem_addr;
      at_end_d = 1'b0;
    end else if (host_wr || host_rd) begin
      if ((WRAP == 0) && (ptr_q == LAST_ADDR)) at_end_d = 1'b1;
      else                                     ptr_d    = ptr_q + 1'b1;
    end
    if (file_close) at_end_d = 1'b0;
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      ptr_q    <= '0;
      at_end_q <= 1'b0;
      r_open_q <= 1'b0;
      w_open_q <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      at_end_q <= at_end_d;
      r_open_q <= bus.user_r_mem_open;
      w_open_q <= bus.user_w_mem_open;
    end
  end

  xillybus_tdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk       (bus_clk),
    .rst_n     (bus_rst_n),
    .a_en_i    (host_rd),
    .a_we_i    (host_wr),
    .a_addr_i  (ptr_q),
    .a_wdata_i (bus.user_w_mem_data),
    .a_rdata_o (bus.user_r_mem_data),
    .b_en_i    (bus.loc_en),
    .b_we_i    (loc_wr),
    .b_addr_i  (bus.loc_addr),
    .b_wdata_i (bus.loc_wdata),
    .b_rdata_o (bus.loc_rdata)
  );

  assign bus.user_r_mem_empty = end_flag;
  assign bus.user_r_mem_eof   = end_flag;
  assign bus.user_w_mem_full  = end_flag;

endmodule
